// File: rtl/adder4.sv
// 4-bit unsigned adder with registered sum and sticky carry flag.
// Define ADDER4_OVF_CNT_EN to add a saturating carry-cycle counter.
module adder4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] result,
  output logic [4:0] result_q,
  output logic       carry_seen
`ifdef ADDER4_OVF_CNT_EN
  ,
  output logic [7:0] ovf_count
`endif
);

  logic [4:0] sum_d, sum_q;
  logic       seen_d, seen_q;
  logic       carry;

  assign result = {1'b0, a} + {1'b0, b};
  assign carry  = result[4];

  always_comb begin
    sum_d  = result;
    seen_d = seen_q | carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 5'd0;
      seen_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      seen_q <= seen_d;
    end
  end

  assign result_q   = sum_q;
  assign carry_seen = seen_q;

`ifdef ADDER4_OVF_CNT_EN
  logic [7:0] cnt_d, cnt_q;

  // Saturate rather than wrap so a long carry run never reads as small.
  always_comb begin
    cnt_d = cnt_q;
    if (carry && (cnt_q != 8'd255)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_count = cnt_q;
`endif

endmodule

// File: tb/tb_adder4.sv
// Self-checking bench for adder4: directed corners plus random
// stimulus against an integer reference model.
module tb_adder4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [4:0] result;
  logic [4:0] result_q;
  logic       carry_seen;
`ifdef ADDER4_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  int checks = 0;
  int errors = 0;

  int  m_q;
  int  m_seen;
  int  m_cnt;
  bit  m_valid = 0;

  adder4 dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .result     (result),
    .result_q   (result_q),
    .carry_seen (carry_seen)
`ifdef ADDER4_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_x(input string tag, input logic [7:0] obs,
                       input int exp);
    if ($isunknown(obs)) begin
      checks++;
      errors++;
      $error("FAIL %s: observed X expected %0d", tag, exp);
    end else begin
      chk(tag, int'(obs), exp);
    end
  endtask

  // One clock step: drive, check combinational sum, clock, check state.
  task automatic step(input int av, input int bv, input bit r);
    int s;
    @(negedge clk);
    a   = 4'(av);
    b   = 4'(bv);
    rst = r;
    s   = av + bv;
    #1;
    chk_x("result", {3'b0, result}, s);
    @(posedge clk);
    #1;
    if (r) begin
      m_q     = 0;
      m_seen  = 0;
      m_cnt   = 0;
      m_valid = 1;
    end else begin
      m_q = s;
      if (s > 15) begin
        m_seen = 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
    if (m_valid) begin
      chk_x("result_q", {3'b0, result_q}, m_q);
      chk_x("carry_seen", {7'b0, carry_seen}, m_seen);
`ifdef ADDER4_OVF_CNT_EN
      chk_x("ovf_count", ovf_count, m_cnt);
`endif
    end
  endtask

  int pa[10] = '{0, 1, 15, 7, 8, 15, 9, 12, 0, 15};
  int pb[10] = '{0, 1, 15, 8, 8, 1, 6, 3, 15, 0};

  initial begin
    a   = 4'd0;
    b   = 4'd0;
    rst = 1'b1;

    step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(pa[i], pb[i], 0);

    step(5, 5, 1);
    step(3, 4, 0);

    step(15, 15, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(2, 2, 1);
    step(15, 15, 1);
    step(0, 0, 0);

`ifdef ADDER4_OVF_CNT_EN
    for (int i = 0; i < 300; i++) step(15, 1, 0);
    step(15, 1, 1);
`endif

    for (int i = 0; i < 200; i++) begin
      step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
